// File: rtl/rv32_dec_exec_wb.sv
// Three-stage RV32 decode / execute / write-back slice with word-indexed PC,
// operand forwarding from the write stage and a private 256-word data memory.
module rv32_dec_exec_wb (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          DECODER_ENABLED,
  input  logic          EXECUTER_ENABLED,
  input  logic          WRITER_ENABLED,
  input  logic [31:0]   INSTRUCTION,
  input  logic [31:0]   PC,
  input  logic [1023:0] REGISTER_FILE,
  output logic          CONDITIONAL_JUMP,
  output logic          MRET,
  output logic [31:0]   JUMP_DEST,
  output logic          WRITE_ENABLE,
  output logic [4:0]    WRITE_RD,
  output logic [31:0]   WRITE_DATA,
  output logic [31:0]   WB_PC
);

  typedef enum logic [3:0] {
    C_NOP, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_OPIMM, C_OP, C_MRET
  } op_class_e;

  typedef struct packed {
    logic        valid;
    op_class_e   cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;      // funct7[5]: SUB / SRA / SRAI select
    logic [31:0] imm;
    logic [31:0] pc;
  } dec_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] jump_dest;
  } ex_t;

  function automatic logic cls_writes(input op_class_e c);
    case (c)
      C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // x0 reads zero; the instruction in the write stage overrides the file.
  function automatic logic [31:0] read_src(input logic [4:0] rs, input logic [1023:0] rf,
                                           input logic fwd_en, input logic [4:0] fwd_rd,
                                           input logic [31:0] fwd_data);
    if (rs == 5'd0) return 32'd0;
    if (fwd_en && (fwd_rd == rs)) return fwd_data;
    return rf[{rs, 5'b0} +: 32];
  endfunction

  dec_t        dec_d, dec_q;
  ex_t         ex_d, ex_q;
  op_class_e   dec_cls;
  logic [31:0] dec_imm;
  logic [31:0] op_a, op_b, alu_b, alu_res, imm_w;
  logic        taken;
  logic [7:0]  mem_idx;
  logic        mem_we;
  logic [31:0] mem [0:255];

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = INSTRUCTION[6:0];
  assign f3  = INSTRUCTION[14:12];
  assign f7  = INSTRUCTION[31:25];

  // Classify the fetched instruction and build its sign-extended immediate.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    dec_cls = C_NOP;
    dec_imm = 32'd0;
    case (opc)
      7'b0110111: begin dec_cls = C_LUI;   dec_imm = {INSTRUCTION[31:12], 12'b0}; end
      7'b0010111: begin dec_cls = C_AUIPC; dec_imm = {INSTRUCTION[31:12], 12'b0}; end
      7'b1101111: begin
        dec_cls = C_JAL;
        dec_imm = {{12{INSTRUCTION[31]}}, INSTRUCTION[19:12], INSTRUCTION[20],
                   INSTRUCTION[30:21], 1'b0};
      end
      7'b1100111: if (f3 == 3'b000) begin
        dec_cls = C_JALR; dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
      end
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
        dec_cls = C_BRANCH;
        dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[7], INSTRUCTION[30:25],
                   INSTRUCTION[11:8], 1'b0};
      end
      7'b0000011: if (f3 == 3'b010) begin
        dec_cls = C_LOAD; dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
      end
      7'b0100011: if (f3 == 3'b010) begin
        dec_cls = C_STORE; dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
      end
      7'b0010011: if ((f3 == 3'b001 && f7 == 7'h00) ||
                      (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)) ||
                      (f3 != 3'b001 && f3 != 3'b101)) begin
        dec_cls = C_OPIMM; dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
      end
      7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
        dec_cls = C_OP;
      end
      7'b1110011: if (INSTRUCTION == 32'h3020_0073) dec_cls = C_MRET;
      default: ;
    endcase
  end

  // Next decode register: a bubble when disabled, otherwise the classified fields.
  always_comb begin
    dec_d = '0;
    if (DECODER_ENABLED) begin
      dec_d.valid = 1'b1;
      dec_d.pc    = PC - 32'd1;
      if (dec_cls != C_NOP) begin
        dec_d.cls    = dec_cls;
        dec_d.rd     = cls_writes(dec_cls) ? INSTRUCTION[11:7] : 5'd0;
        dec_d.rs1    = INSTRUCTION[19:15];
        dec_d.rs2    = INSTRUCTION[24:20];
        dec_d.funct3 = f3;
        dec_d.alt    = INSTRUCTION[30];
        dec_d.imm    = dec_imm;
      end
    end
  end

  // Forwarded operands, ALU, branch condition and memory index for the execute stage.
  always_comb begin
    op_a    = read_src(dec_q.rs1, REGISTER_FILE, WRITE_ENABLE, WRITE_RD, WRITE_DATA);
    op_b    = read_src(dec_q.rs2, REGISTER_FILE, WRITE_ENABLE, WRITE_RD, WRITE_DATA);
    alu_b   = (dec_q.cls == C_OP) ? op_b : dec_q.imm;
    imm_w   = $signed(dec_q.imm) >>> 2;
    mem_idx = 8'((op_a[9:0] + dec_q.imm[9:0]) >> 2);
    alu_res = 32'd0;
    case (dec_q.funct3)
      3'b000: alu_res = (dec_q.cls == C_OP && dec_q.alt) ? op_a - alu_b : op_a + alu_b;
      3'b001: alu_res = op_a << alu_b[4:0];
      3'b010: alu_res = {31'd0, $signed(op_a) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, op_a < alu_b};
      3'b100: alu_res = op_a ^ alu_b;
      3'b101: alu_res = dec_q.alt ? 32'($signed(op_a) >>> alu_b[4:0]) : op_a >> alu_b[4:0];
      3'b110: alu_res = op_a | alu_b;
      3'b111: alu_res = op_a & alu_b;
      default: ;
    endcase
    taken = 1'b0;
    case (dec_q.funct3)
      3'b000: taken = (op_a == op_b);
      3'b001: taken = (op_a != op_b);
      3'b100: taken = ($signed(op_a) <  $signed(op_b));
      3'b101: taken = ($signed(op_a) >= $signed(op_b));
      3'b110: taken = (op_a <  op_b);
      3'b111: taken = (op_a >= op_b);
      default: ;
    endcase
  end

  // Next execute register: result, next-PC and control for the write stage.
  always_comb begin
    ex_d   = '0;
    mem_we = 1'b0;
    if (dec_q.valid && EXECUTER_ENABLED) begin
      ex_d.pc        = dec_q.pc;
      ex_d.rd        = dec_q.rd;
      ex_d.wr        = cls_writes(dec_q.cls);
      ex_d.jump_dest = dec_q.pc + 32'd1;
      case (dec_q.cls)
        C_LUI:   ex_d.data = dec_q.imm;
        C_AUIPC: ex_d.data = dec_q.pc + imm_w;
        C_JAL: begin
          // JAL offsets count from the fetch-slot PC, one above the latched pc.
          ex_d.data      = dec_q.pc + 32'd1;
          ex_d.jump_dest = dec_q.pc + 32'd1 + imm_w;
        end
        C_JALR: begin
          ex_d.data      = dec_q.pc + 32'd1;
          ex_d.jump_dest = op_a + imm_w;
        end
        C_BRANCH: if (taken) ex_d.jump_dest = dec_q.pc + imm_w;
        C_LOAD:   ex_d.data = mem[mem_idx];
        C_STORE:  mem_we = 1'b1;
        C_OPIMM, C_OP: ex_d.data = alu_res;
        default: ;
      endcase
    end
  end

  // Pipeline registers; reset leaves a NOP bubble in both stages.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      dec_q <= '0;
      ex_q  <= '0;
    end else begin
      dec_q <= dec_d;
      ex_q  <= ex_d;
    end
  end

  // Store port; a reset clears the decode register first, so no store is pending.
  // NOTE: data memory is not reset, so its contents survive RSTN.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_idx] <= op_b;
  end

  assign CONDITIONAL_JUMP = dec_q.cls inside {C_JAL, C_JALR, C_BRANCH};
  assign MRET             = (dec_q.cls == C_MRET);
  assign JUMP_DEST        = ex_q.jump_dest;
  assign WRITE_ENABLE     = WRITER_ENABLED & ex_q.wr & (ex_q.rd != 5'd0);
  assign WRITE_RD         = ex_q.rd;
  assign WRITE_DATA       = ex_q.data;
  assign WB_PC            = ex_q.pc;

endmodule

// File: tb/tb_rv32_dec_exec_wb.sv
// Directed bench for rv32_dec_exec_wb: a vector table of single instructions
// followed by hand-written pipeline sequences.
module tb_rv32_dec_exec_wb;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          DECODER_ENABLED, EXECUTER_ENABLED, WRITER_ENABLED;
  logic [31:0]   INSTRUCTION, PC;
  logic [1023:0] REGISTER_FILE;
  logic          CONDITIONAL_JUMP, MRET, WRITE_ENABLE;
  logic [31:0]   JUMP_DEST, WRITE_DATA, WB_PC;
  logic [4:0]    WRITE_RD;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  rv32_dec_exec_wb dut (
    .CLK(CLK), .RSTN(RSTN),
    .DECODER_ENABLED(DECODER_ENABLED), .EXECUTER_ENABLED(EXECUTER_ENABLED),
    .WRITER_ENABLED(WRITER_ENABLED), .INSTRUCTION(INSTRUCTION), .PC(PC),
    .REGISTER_FILE(REGISTER_FILE), .CONDITIONAL_JUMP(CONDITIONAL_JUMP), .MRET(MRET),
    .JUMP_DEST(JUMP_DEST), .WRITE_ENABLE(WRITE_ENABLE), .WRITE_RD(WRITE_RD),
    .WRITE_DATA(WRITE_DATA), .WB_PC(WB_PC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        cj;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] jd;
    logic [31:0] wbpc;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    REGISTER_FILE[idx*32 +: 32] = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cj"},   {31'd0, CONDITIONAL_JUMP}, 32'd0);
    check({tag, " mret"}, {31'd0, MRET}, 32'd0);
    check({tag, " jd"},   JUMP_DEST, 32'd0);
    check({tag, " we"},   {31'd0, WRITE_ENABLE}, 32'd0);
    check({tag, " rd"},   {27'd0, WRITE_RD}, 32'd0);
    check({tag, " data"}, WRITE_DATA, 32'd0);
    check({tag, " wbpc"}, WB_PC, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //             name      instr          pc   x1            x2            cj   we   rd  data           jd    wbpc
    vecs[0]  = '{"addi15", 32'h0010_0793,  9, 32'd0,        32'd0,        1'b0,1'b1,15, 32'd1,         9,    8};
    vecs[1]  = '{"add",    32'h0020_81B3, 20, 32'd7,        32'd10,       1'b0,1'b1, 3, 32'd17,       20,   19};
    vecs[2]  = '{"sub",    32'h4020_81B3, 21, 32'd5,        32'd7,        1'b0,1'b1, 3, 32'hFFFF_FFFE,21,   20};
    vecs[3]  = '{"slt",    32'h0020_A1B3, 22, 32'hFFFF_FFFF,32'd1,        1'b0,1'b1, 3, 32'd1,        22,   21};
    vecs[4]  = '{"sltu",   32'h0020_B1B3, 23, 32'hFFFF_FFFF,32'd1,        1'b0,1'b1, 3, 32'd0,        23,   22};
    vecs[5]  = '{"sra",    32'h4020_D1B3, 24, 32'h8000_0000,32'h21,       1'b0,1'b1, 3, 32'hC000_0000,24,   23};
    vecs[6]  = '{"srli",   32'h0040_D193, 25, 32'hF000_0000,32'd0,        1'b0,1'b1, 3, 32'h0F00_0000,25,   24};
    vecs[7]  = '{"xori",   32'hFFF0_C193, 26, 32'h0000_FFFF,32'd0,        1'b0,1'b1, 3, 32'hFFFF_0000,26,   25};
    vecs[8]  = '{"lui",    32'h1234_52B7, 27, 32'd0,        32'd0,        1'b0,1'b1, 5, 32'h1234_5000,27,   26};
    vecs[9]  = '{"addi_x0",32'h0050_8013, 28, 32'd3,        32'd0,        1'b0,1'b0, 0, 32'd8,        28,   27};
    vecs[10] = '{"illegal",32'hFFFF_FFFF, 50, 32'd0,        32'd0,        1'b0,1'b0, 0, 32'd0,        50,   49};
    vecs[11] = '{"jalr",   32'h0081_00E7, 30, 32'd0,        32'd100,      1'b1,1'b1, 1, 32'd30,      102,   29};
    vecs[12] = '{"bne_t",  32'hFE20_9CE3, 40, 32'd1,        32'd2,        1'b1,1'b0, 0, 32'd0,        37,   39};
    vecs[13] = '{"bgeu_nt",32'h0020_F863, 60, 32'd1,        32'hFFFF_FFFF,1'b1,1'b0, 0, 32'd0,        60,   59};

    RSTN = 1'b0;
    DECODER_ENABLED = 1'b1; EXECUTER_ENABLED = 1'b1; WRITER_ENABLED = 1'b1;
    INSTRUCTION = NOP; PC = 32'd0; REGISTER_FILE = '0;
    #12;
    check_all_zero("reset");
    RSTN = 1'b1;
    tick();

    // Vector table: x0 carries garbage to prove it always reads zero.
    for (int i = 0; i < 14; i++) begin
      REGISTER_FILE = '0;
      set_reg(0, 32'hDEAD_BEEF);
      set_reg(1, vecs[i].x1);
      set_reg(2, vecs[i].x2);
      INSTRUCTION = vecs[i].instr;
      PC = vecs[i].pc;
      tick();
      check({vecs[i].name, " cj"}, {31'd0, CONDITIONAL_JUMP}, {31'd0, vecs[i].cj});
      INSTRUCTION = NOP; PC = 32'd0;
      tick();
      check({vecs[i].name, " we"},   {31'd0, WRITE_ENABLE}, {31'd0, vecs[i].we});
      check({vecs[i].name, " rd"},   {27'd0, WRITE_RD}, {27'd0, vecs[i].rd});
      check({vecs[i].name, " data"}, WRITE_DATA, vecs[i].data);
      check({vecs[i].name, " jd"},   JUMP_DEST, vecs[i].jd);
      check({vecs[i].name, " wbpc"}, WB_PC, vecs[i].wbpc);
    end
    REGISTER_FILE = '0;

    // JAL x1,+0x70 from fetch slot 1.
    INSTRUCTION = 32'h0700_00EF; PC = 32'd1;
    tick();
    check("jal cj", {31'd0, CONDITIONAL_JUMP}, 32'd1);
    INSTRUCTION = NOP; PC = 32'd0;
    tick();
    check("jal jd",   JUMP_DEST, 32'd29);
    check("jal we",   {31'd0, WRITE_ENABLE}, 32'd1);
    check("jal rd",   {27'd0, WRITE_RD}, 32'd1);
    check("jal link", WRITE_DATA, 32'd1);

    // SW x1,28(x2) then LW x3,28(x2).
    set_reg(1, 32'd7); set_reg(2, 32'd500);
    INSTRUCTION = 32'h0011_2E23; tick();
    INSTRUCTION = 32'h01C1_2183; tick();
    INSTRUCTION = NOP;           tick();
    check("lw we",   {31'd0, WRITE_ENABLE}, 32'd1);
    check("lw rd",   {27'd0, WRITE_RD}, 32'd3);
    check("lw data", WRITE_DATA, 32'd7);

    // Store dropped while the execute stage is disabled.
    set_reg(1, 32'd99);
    INSTRUCTION = 32'h0011_2E23; tick();
    INSTRUCTION = NOP; EXECUTER_ENABLED = 1'b0; tick();
    check("exdis we", {31'd0, WRITE_ENABLE}, 32'd0);
    check("exdis jd", JUMP_DEST, 32'd0);
    EXECUTER_ENABLED = 1'b1;
    INSTRUCTION = 32'h01C1_2183; tick();
    INSTRUCTION = NOP;           tick();
    check("exdis lw data", WRITE_DATA, 32'd7);

    // Reset while a store sits in decode: discarded, memory retained.
    set_reg(1, 32'd55);
    INSTRUCTION = 32'h0011_2E23; tick();
    RSTN = 1'b0;
    #1;
    check_all_zero("midreset");
    INSTRUCTION = NOP; tick();
    RSTN = 1'b1;
    INSTRUCTION = 32'h01C1_2183; tick();
    INSTRUCTION = NOP;           tick();
    check("midreset lw data", WRITE_DATA, 32'd7);

    // Back-to-back dependency forwarded from the write stage.
    REGISTER_FILE = '0;
    INSTRUCTION = 32'h0050_0793; tick();
    INSTRUCTION = 32'h00F7_8733; tick();
    check("fwd first rd",   {27'd0, WRITE_RD}, 32'd15);
    check("fwd first data", WRITE_DATA, 32'd5);
    INSTRUCTION = NOP; tick();
    check("fwd add rd",   {27'd0, WRITE_RD}, 32'd14);
    check("fwd add data", WRITE_DATA, 32'd10);

    // Writer disabled: no write and no forwarding.
    WRITER_ENABLED = 1'b0;
    INSTRUCTION = 32'h0050_0793; tick();
    INSTRUCTION = 32'h00F7_8733; tick();
    check("wrdis we",   {31'd0, WRITE_ENABLE}, 32'd0);
    check("wrdis data", WRITE_DATA, 32'd5);
    INSTRUCTION = NOP; tick();
    check("wrdis add data", WRITE_DATA, 32'd0);
    WRITER_ENABLED = 1'b1;

    // BLT x15,x14,+12 at PC=10, not taken then taken.
    set_reg(15, 32'd1); set_reg(14, 32'd0);
    INSTRUCTION = 32'h00E7_C663; PC = 32'd10; tick();
    check("blt cj", {31'd0, CONDITIONAL_JUMP}, 32'd1);
    INSTRUCTION = NOP; tick();
    check("blt nt jd", JUMP_DEST, 32'd10);
    set_reg(14, 32'd5);
    INSTRUCTION = 32'h00E7_C663; PC = 32'd10; tick();
    INSTRUCTION = NOP; tick();
    check("blt t jd", JUMP_DEST, 32'd12);
    REGISTER_FILE = '0;

    // MRET flagged in decode for one cycle, no write later.
    INSTRUCTION = 32'h3020_0073; tick();
    check("mret flag", {31'd0, MRET}, 32'd1);
    check("mret cj",   {31'd0, CONDITIONAL_JUMP}, 32'd0);
    INSTRUCTION = NOP; tick();
    check("mret drop", {31'd0, MRET}, 32'd0);
    check("mret we",   {31'd0, WRITE_ENABLE}, 32'd0);

    // Decoder disabled: ADDI x15 is replaced by a bubble.
    DECODER_ENABLED = 1'b0;
    INSTRUCTION = 32'h0010_0793; PC = 32'd9; tick();
    tick();
    check("decdis we",   {31'd0, WRITE_ENABLE}, 32'd0);
    check("decdis wbpc", WB_PC, 32'd0);
    DECODER_ENABLED = 1'b1;

    // Reset after live traffic clears every output.
    INSTRUCTION = 32'h0700_00EF; PC = 32'd1; tick();
    INSTRUCTION = NOP; tick();
    RSTN = 1'b0;
    #1;
    check_all_zero("final reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
